mat_stream_loader: RTL and testbench
====================================

// Module: mat_stream_loader
// PURPOSE
//   Sequential front/back end for the combinational mul_matrix array. Accepts a
//   word stream of 32-bit elements over valid/ready, assembles flattened
//   matrices A and B, drives them to mul_matrix, captures the product C and
//   streams C back out over valid/ready. One job (A, B in; C out) at a time.
// PARAMETERS
//   N   2   matrix dimension; matrices are N x N, 32-bit unsigned elements
// PORTS
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         in_data holds an element
//   in_ready   out  1         loader accepts an element this cycle
//   in_data    in   32        element word
//   mat_a      out  32*N*N    flattened A to mul_matrix.mat_A
//   mat_b      out  32*N*N    flattened B to mul_matrix.mat_B
//   mat_c      in   32*N*N    flattened product from mul_matrix.mat_out
//   out_valid  out  1         out_data holds a C element
//   out_ready  in   1         consumer takes out_data this cycle
//   out_data   out  32        C element word
//   out_last   out  1         high with the final C element (index N*N-1)
//   busy       out  1         high in any state other than LOAD_A with idx 0
// BEHAVIOUR
//   Layout: element (row i, col j) occupies word index w = i + N*j, i.e.
//     bits [w*32+31 : w*32], the same for A, B and C, and for stream order.
//   Transfer on in side = in_valid & in_ready; on out side = out_valid & out_ready.
//   Element counter idx, width max(1,$clog2(N*N)), counts 0..N*N-1.
//   FSM states:
//     LOAD_A : in_ready=1. Each transfer writes in_data to mat_a word idx.
//              idx==N*N-1 on transfer -> idx=0, go LOAD_B; else idx+1.
//     LOAD_B : in_ready=1. Same, into mat_b; last transfer -> CAPTURE.
//     CAPTURE: in_ready=0, out_valid=0. One cycle; registers c_reg <= mat_c
//              (mat_a/mat_b have been stable >=1 cycle); idx=0; go DRAIN.
//     DRAIN  : out_valid=1, out_data = c_reg word idx, out_last=(idx==N*N-1).
//              On transfer: last -> idx=0, go LOAD_A; else idx+1.
//              No transfer: out_data/out_last held unchanged.
//   Latency: first C word valid 2 cycles after the clock edge taking the last
//     B word (edge -> CAPTURE cycle -> DRAIN cycle).
//   in_ready and out_valid are never high in the same cycle. in_valid outside
//     LOAD_A/LOAD_B is ignored (no transfer). out_ready outside DRAIN ignored.
//   mat_a/mat_b hold their contents from load until overwritten by next job;
//     words not yet rewritten in a new job keep previous job's values.
//   Arithmetic: none in this block; C wraps modulo 2^32 inside mul_matrix.
//   N=1: each load phase is one word; out_last high on the single C word.
//   Reset (async, any state, mid-job included): state=LOAD_A, idx=0,
//     mat_a=0, mat_b=0, c_reg=0, in_ready=1 after release, out_valid=0,
//     out_data=0, out_last=0, busy=0. Partially loaded job is discarded.
// TESTING
//   1 N=2, stream A=1,0,10,1 then B=1,0,1,1, out_ready=1 -> out 1,0,11,1;
//     out_last only on 4th word; first out_valid 2 cycles after last B edge.
//   2 Same job, out_ready low for 3 cycles on word 2 -> out_data=11 held
//     stable, out_valid stays 1, no words dropped or duplicated.
//   3 in_valid toggling every other cycle during load -> only accepted words
//     stored; result identical to scenario 1; in_ready=0 during CAPTURE/DRAIN.
//   4 Back-to-back jobs: second A=2,0,0,2 (2I), B=1,2,3,4 -> out 2,4,6,8;
//     in_ready returns 1 the cycle after first job's last out transfer.
//   5 Assert rst_n low after 3 A words, release, then full job of scenario 1
//     -> outputs zeroed during reset, result 1,0,11,1 (stale words discarded).
//   6 Overflow: A all 0xFFFFFFFF, B identity -> out all 0xFFFFFFFF; A=B all
//     0x80000000 -> out all 0x00000000 (mod 2^32 wrap).

Source files
------------

// File: rtl/mat_stream_loader_if.sv
// Bundle of the element stream handshakes and the flattened matrix buses between
// mat_stream_loader (slave) and its environment (master).
interface mat_stream_loader_if #(
    parameter int N = 2
);
    localparam int W = 32 * N * N;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic [W-1:0]  mat_a;
    logic [W-1:0]  mat_b;
    logic [W-1:0]  mat_c;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;

    modport slave (
        input  in_valid, in_data, out_ready, mat_c,
        output in_ready, out_valid, out_data, out_last, mat_a, mat_b, busy
    );

    modport master (
        output in_valid, in_data, out_ready, mat_c,
        input  in_ready, out_valid, out_data, out_last, mat_a, mat_b, busy
    );
endinterface

// File: rtl/mat_stream_loader.sv
// Streams A and B into flattened registers for the combinational mul_matrix,
// captures its product once, then streams C back out word by word.
module mat_stream_loader #(
    parameter int N = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mat_stream_loader_if.slave bus
);
    localparam int NN    = N * N;
    localparam int W     = 32 * NN;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] LOAD_A  = 2'd0;
    localparam logic [1:0] LOAD_B  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     mat_a_q, mat_a_d;
    logic [W-1:0]     mat_b_q, mat_b_d;
    logic [W-1:0]     c_q, c_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;
    logic idx_last;

    assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign out_valid = (state_q == DRAIN);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;
    assign idx_last  = (idx_q == IDX_LAST);

    // NOTE: every variable gets a default at the top of the block so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        c_d     = c_q;
        case (state_q)
            LOAD_A: begin
                if (in_fire) begin
                    mat_a_d[32*int'(idx_q) +: 32] = bus.in_data;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            LOAD_B: begin
                if (in_fire) begin
                    mat_b_d[32*int'(idx_q) +: 32] = bus.in_data;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = CAPTURE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            CAPTURE: begin
                // mat_a/mat_b settled on the previous edge, so mat_c is valid now.
                c_d     = bus.mat_c;
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_fire) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = LOAD_A;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            c_q     <= c_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? c_q[32*int'(idx_q) +: 32] : 32'd0;
    assign bus.out_last  = out_valid & idx_last;
    assign bus.mat_a     = mat_a_q;
    assign bus.mat_b     = mat_b_q;
    assign bus.busy      = !((state_q == LOAD_A) && (idx_q == '0));
endmodule

// File: tb/tb_mat_stream_loader.sv
// Directed and randomized jobs for mat_stream_loader; a behavioural matrix
// product stands in for mul_matrix and also supplies expected C values.
module tb_mat_stream_loader;
    localparam int N     = 2;
    localparam int NN    = N * N;
    localparam int W     = 32 * NN;
    localparam int LIMIT = 200;

    typedef logic [31:0] vec_t [NN];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mat_stream_loader_if #(.N(N)) bus ();
    mat_stream_loader #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Element (i,j) lives at word i + N*j.
    function automatic vec_t matmul(input vec_t a, input vec_t b);
        vec_t c;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                logic [31:0] acc = 32'd0;
                for (int k = 0; k < N; k++)
                    acc = acc + a[i + N*k] * b[k + N*j];
                c[i + N*j] = acc;
            end
        return c;
    endfunction

    function automatic logic [W-1:0] pack(input vec_t v);
        logic [W-1:0] p = '0;
        for (int w = 0; w < NN; w++) p[32*w +: 32] = v[w];
        return p;
    endfunction

    function automatic vec_t unpack(input logic [W-1:0] p);
        vec_t v;
        for (int w = 0; w < NN; w++) v[w] = p[32*w +: 32];
        return v;
    endfunction

    always_comb bus.mat_c = pack(matmul(unpack(bus.mat_a), unpack(bus.mat_b)));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_flat(input string tag, input logic [W-1:0] flat, input vec_t exp);
        for (int w = 0; w < NN; w++) check(tag, flat[32*w +: 32], exp[w]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"},  bus.out_data,       32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    // Offers one word and returns at #1 after the edge that accepted it.
    task automatic push(input logic [31:0] w, input bit gap);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        while (!bus.in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("push_timeout", 32'(n >= LIMIT), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // stall_mode: 0 none, 1 hold word 2 for 3 cycles, 2 random back-pressure.
    task automatic drain(input vec_t exp, input int stall_mode);
        int k = 0, waited = 0, st = 0;
        while (k < NN && waited < LIMIT) begin
            case (stall_mode)
                1:       bus.out_ready = !(k == 2 && st < 3);
                2:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (waited == 0) check("first_valid", 32'(bus.out_valid), 32'd1);
            check("in_ready_drain", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid) begin
                check($sformatf("out_data[%0d]", k), bus.out_data, exp[k]);
                check($sformatf("out_last[%0d]", k), 32'(bus.out_last), 32'(k == NN-1));
                if (bus.out_ready) k++;
                else st++;
            end
            @(posedge clk); #1;
            waited++;
        end
        bus.out_ready = 1'b0;
        check("drain_timeout", 32'(k < NN), 32'd0);
    endtask

    task automatic run_job(input vec_t a, input vec_t b, input vec_t exp,
                           input bit gaps, input int stall_mode, input bit junk);
        for (int w = 0; w < NN; w++) push(a[w], gaps && (w != NN-1 || 1'b1));
        check_flat("mat_a", bus.mat_a, a);
        for (int w = 0; w < NN; w++) push(b[w], gaps && (w != NN-1));
        // Now in the cycle after the edge that took the last B word.
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        check("capture_out_valid", 32'(bus.out_valid), 32'd0);
        check("capture_in_ready",  32'(bus.in_ready),  32'd0);
        check("capture_busy",      32'(bus.busy),      32'd1);
        check_flat("mat_b", bus.mat_b, b);
        @(posedge clk); #1;
        drain(exp, stall_mode);
        bus.in_valid = 1'b0;
        check("post_in_ready",  32'(bus.in_ready),  32'd1);
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_busy",      32'(bus.busy),      32'd0);
    endtask

    initial begin
        vec_t a1, b1, c1, a2, b2, c2, zero, ones, ident, half, r_a, r_b;
        a1 = '{32'd1, 32'd0, 32'd10, 32'd1};
        b1 = '{32'd1, 32'd0, 32'd1, 32'd1};
        c1 = '{32'd1, 32'd0, 32'd11, 32'd1};
        a2 = '{32'd2, 32'd0, 32'd0, 32'd2};
        b2 = '{32'd1, 32'd2, 32'd3, 32'd4};
        c2 = '{32'd2, 32'd4, 32'd6, 32'd8};
        zero  = '{32'd0, 32'd0, 32'd0, 32'd0};
        ones  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ident = '{32'd1, 32'd0, 32'd0, 32'd1};
        half  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};

        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;

        #2;
        check_idle_outputs("reset");
        check_flat("reset_mat_a", bus.mat_a, zero);
        check_flat("reset_mat_b", bus.mat_b, zero);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenario 1: basic job, continuous out_ready.
        run_job(a1, b1, c1, 1'b0, 0, 1'b0);
        // Scenario 2: back-pressure on word 2.
        run_job(a1, b1, c1, 1'b0, 1, 1'b0);
        // Scenario 3: gaps in in_valid, junk offered while not ready.
        run_job(a1, b1, c1, 1'b1, 0, 1'b1);
        // Scenario 4: back-to-back jobs.
        run_job(a1, b1, c1, 1'b0, 0, 1'b0);
        run_job(a2, b2, c2, 1'b0, 0, 1'b0);

        // Scenario 5: reset mid-load discards partial job.
        push(32'd7, 1'b0);
        push(32'd8, 1'b0);
        push(32'd9, 1'b0);
        check("midjob_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        check_flat("midreset_mat_a", bus.mat_a, zero);
        check_flat("midreset_mat_b", bus.mat_b, zero);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(a1, b1, c1, 1'b0, 0, 1'b0);

        // Scenario 6: modulo 2^32 wrap.
        run_job(ones, ident, ones, 1'b0, 0, 1'b0);
        run_job(half, half, zero, 1'b0, 0, 1'b0);

        // Randomized jobs against the behavioural product.
        for (int j = 0; j < 6; j++) begin
            for (int w = 0; w < NN; w++) begin
                r_a[w] = (j < 3) ? $urandom : 32'($urandom_range(0, 15));
                r_b[w] = (j < 3) ? $urandom : 32'($urandom_range(0, 15));
            end
            run_job(r_a, r_b, matmul(r_a, r_b), 1'($urandom_range(0, 1)), 2,
                    1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
